bullet_pool: RTL and testbench
==============================

// Module: bullet_pool
// PURPOSE
//  Pool of N independent bullet slots for the shooting game: accepts fire requests, moves live
//  bullets vertically once per frame, retires them off-screen or on kill, and renders the
//  per-pixel bullet layer. It replaces the single-bullet sprite lookup. Sits between
//  player/enemy control (fire, kill) and the pixel mixer (pix_on).
// PARAMETERS
//  N_BULLETS  4    number of bullet slots (1..16)
//  XW         10   pixel x coordinate width
//  YW         10   pixel y coordinate width
//  V_RES      480  visible lines; bullet y must stay in [0, V_RES-SPR)
//  SPR        6    sprite edge in pixels (square)
//  SPEED      4    pixels moved per frame_tick (1..SPR)
// PORTS
//  clk         in   1            system/pixel clock
//  rst_n       in   1            asynchronous active-low reset
//  frame_tick  in   1            1-cycle pulse once per frame (start of vblank)
//  fire        in   1            fire request, sampled every cycle
//  fire_x      in   XW           top-left x of new bullet
//  fire_y      in   YW           top-left y of new bullet
//  fire_dir    in   1            0 = up (y decreasing), 1 = down
//  fire_ack    out  1            pulse: request accepted
//  fire_drop   out  1            pulse: request rejected, pool full
//  kill        in   1            retire slot kill_idx (collision logic)
//  kill_idx    in   $clog2(N)    slot to retire
//  pix_x       in   XW           current beam x
//  pix_y       in   YW           current beam y
//  pix_on      out  1            bullet pixel lit at registered beam position
//  pix_id      out  $clog2(N)    slot owning the lit pixel (lowest index wins)
//  active      out  N_BULLETS    live-slot mask
// BEHAVIOUR
//  Reset: all slots inactive; every x, y and dir is 0. fire_ack, fire_drop, pix_on, pix_id and
//   active reset to 0.
//  Free-slot selection uses the registered active mask only. Slots freed this cycle become
//   usable next cycle.
//  Fire: if fire and any slot is free, the lowest free index loads {fire_x, fire_y, fire_dir}
//   and goes active on the next edge. fire_ack is high for that one cycle. If no slot is free,
//   fire_drop is high one cycle instead and no state changes. Holding fire high fires every
//   cycle.
//  Move: on frame_tick, each active slot not loaded this cycle moves by SPEED:
//   - up: if y < SPEED, retire; else y -= SPEED.
//   - down: if y + SPEED > V_RES-SPR, retire; else y += SPEED.
//   - Compare in YW+1 bits. No wrap-around is permitted.
//  A slot loaded by fire in the same cycle as frame_tick keeps fire_y unmoved.
//  Kill: kill with an active slot clears it on the next edge. Kill of an inactive slot is
//   ignored. Kill beats move for the same slot in the same cycle.
//  Render: for each slot, dx = pix_x - x and dy = pix_y - y.
//   - hit = active && dx < SPR && dy < SPR, computed unsigned so negative values fail.
//   - lit = hit && ROM[dy][dx].
//   - pix_on / pix_id are registered: latency 1 cycle from pix_x/pix_y.
//   - If no slot is lit, pix_id holds 0.
//  Sprite ROM (6x6, row=y, col=x), rows in order:
//   001100 / 011110 / 111111 / 111111 / 011110 / 001100.
//  Fire, move and kill act on slot state only. Rendering always reflects the registered state.
//  Asynchronous reset mid-frame clears all slots immediately; no pending fire survives.
// STRUCTURE
//  Shared package bullet_pkg:
//   - SPR constant
//   - typedef dir_t {DIR_UP=0, DIR_DN=1}
//   - sprite pattern constant and function spr_bit(dy, dx)
//  Sub-module bullet_sprite_rom:
//   - combinational; inputs dy, dx, en; output bit (0 when en is low or out of range)
//   - one instance per slot via generate
//  Top level: slot registers, priority encoders for free-slot selection and pix_id, and the
//   move/retire logic.
// TESTING
//  1. Reset, then fire at (100,200) up -> fire_ack the next cycle, active=0001. After 3
//     frame_ticks, y=188.
//  2. Five fires, one per cycle, with N=4 -> acks on fires 1-4, fire_drop on fire 5,
//     active=1111.
//  3. Slot at y=2, up, frame_tick -> slot retired, active bit 0. Slot at y=472, down,
//     frame_tick -> retired (472+4 > 474).
//  4. Slot at (100,200). Drive pix (102,200) -> pix_on=1 one cycle later. pix (100,200) -> 0
//     (ROM corner). pix (106,203) -> 0 (outside box).
//  5. Same cycle: frame_tick, kill of slot 1, fire while only slot 1 is active -> slot 1
//     cleared; new bullet goes to slot 0 at fire_y, unmoved.
//  6. Overlapping slots 0 and 2 on a lit pixel -> pix_id=0. Assert rst_n low mid-frame ->
//     active=0 and pix_on=0 immediately.

Source files
------------

// File: rtl/bullet_pkg.sv
// Shared definitions for the bullet pool: sprite size, direction type and
// the 6x6 bullet sprite with a bounds-checked lookup.
package bullet_pkg;

    localparam int SPR    = 6;                // sprite edge in pixels (square)
    localparam int SPR_IW = $clog2(SPR);      // bits needed to index a row/column

    typedef enum logic {
        DIR_UP = 1'b0,                        // y decreasing
        DIR_DN = 1'b1                         // y increasing
    } dir_t;

    // Row 0 is the top of the sprite; within a row the leftmost bit is column 0.
    localparam logic [0:SPR-1][SPR-1:0] SPR_PAT = {
        6'b001100,
        6'b011110,
        6'b111111,
        6'b111111,
        6'b011110,
        6'b001100
    };

    // Sprite pixel at row dy, column dx; anything outside the sprite is dark.
    function automatic logic spr_bit(input logic [SPR_IW-1:0] dy,
                                     input logic [SPR_IW-1:0] dx);
        if (dy >= SPR_IW'(SPR) || dx >= SPR_IW'(SPR)) return 1'b0;
        return SPR_PAT[dy][SPR_IW'(SPR - 1) - dx];
    endfunction

endpackage

// File: rtl/bullet_pool_if.sv
// Control-side handshake of the bullet pool: fire requests with their
// accept/reject pulses, and the kill request from collision logic.
//   master : player/enemy/collision control
//   slave  : bullet_pool
interface bullet_pool_if
    import bullet_pkg::*;
#(
    parameter int N_BULLETS = 4,
    parameter int XW        = 10,
    parameter int YW        = 10
) ();

    localparam int IW = (N_BULLETS > 1) ? $clog2(N_BULLETS) : 1;

    logic          fire;        // fire request, sampled every cycle
    logic [XW-1:0] fire_x;      // top-left x of the new bullet
    logic [YW-1:0] fire_y;      // top-left y of the new bullet
    dir_t          fire_dir;    // travel direction of the new bullet
    logic          fire_ack;    // pulse: request accepted
    logic          fire_drop;   // pulse: request rejected, pool full
    logic          kill;        // retire slot kill_idx
    logic [IW-1:0] kill_idx;

    modport master (
        output fire, fire_x, fire_y, fire_dir, kill, kill_idx,
        input  fire_ack, fire_drop
    );

    modport slave (
        input  fire, fire_x, fire_y, fire_dir, kill, kill_idx,
        output fire_ack, fire_drop
    );

endinterface

// File: rtl/bullet_sprite_rom.sv
// Combinational sprite lookup for one bullet slot.
//   en  : slot is live; when low the output is dark
//   dy  : beam y minus bullet y (unsigned, so a beam above the bullet is huge)
//   dx  : beam x minus bullet x (unsigned, same trick)
//   lit : sprite pixel is on
module bullet_sprite_rom
    import bullet_pkg::*;
#(
    parameter int XW = 10,
    parameter int YW = 10
) (
    input  logic          en,
    input  logic [YW-1:0] dy,
    input  logic [XW-1:0] dx,
    output logic          lit
);

    // The range test on the full-width offsets must come first: the low bits
    // alone would alias offsets such as 64 back onto the sprite.
    assign lit = en && (dy < YW'(SPR)) && (dx < XW'(SPR))
                 && spr_bit(dy[SPR_IW-1:0], dx[SPR_IW-1:0]);

endmodule

// File: rtl/bullet_pool.sv
// Pool of N_BULLETS bullet slots: accepts fire requests into the lowest free
// slot, moves live bullets once per frame, retires them off-screen or on kill,
// and renders the per-pixel bullet layer with one cycle of latency.
//   clk, rst_n  : clock, asynchronous active-low reset
//   frame_tick  : one-cycle pulse per frame, triggers movement
//   ctl         : fire/kill handshake (slave side)
//   pix_x/pix_y : current beam position
//   pix_on      : registered "bullet pixel lit" for the previous beam position
//   pix_id      : lowest slot owning that pixel, 0 when nothing is lit
//   active      : live-slot mask
module bullet_pool
    import bullet_pkg::*;
#(
    parameter int N_BULLETS = 4,
    parameter int XW        = 10,
    parameter int YW        = 10,
    parameter int V_RES     = 480,
    parameter int SPEED     = 4,
    localparam int IW       = (N_BULLETS > 1) ? $clog2(N_BULLETS) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 frame_tick,
    bullet_pool_if.slave         ctl,
    input  logic [XW-1:0]        pix_x,
    input  logic [YW-1:0]        pix_y,
    output logic                 pix_on,
    output logic [IW-1:0]        pix_id,
    output logic [N_BULLETS-1:0] active
);

    // Movement limits widened by one bit so y + SPEED cannot wrap.
    localparam logic [YW:0] SPEED_EXT = (YW+1)'(SPEED);
    localparam logic [YW:0] Y_LIMIT   = (YW+1)'(V_RES - SPR);

    logic [XW-1:0]        x_q   [N_BULLETS];
    logic [XW-1:0]        x_d   [N_BULLETS];
    logic [YW-1:0]        y_q   [N_BULLETS];
    logic [YW-1:0]        y_d   [N_BULLETS];
    dir_t                 dir_q [N_BULLETS];
    dir_t                 dir_d [N_BULLETS];
    logic [N_BULLETS-1:0] act_q, act_d;

    logic                 free_found;
    logic [IW-1:0]        free_idx;
    logic                 ack_q, drop_q;

    logic [N_BULLETS-1:0] lit;
    logic                 pix_on_d, pix_on_q;
    logic [IW-1:0]        pix_id_d, pix_id_q;

    // Lowest free slot, taken from the registered mask only: a slot freed
    // this cycle is not offered until the next one.
    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        for (int i = 0; i < N_BULLETS; i++) begin
            if (!act_q[i] && !free_found) begin
                free_found = 1'b1;
                free_idx   = IW'(i);
            end
        end
    end

    // Per-slot next state. Priority: load (slot is free, so kill cannot
    // apply), then kill, then movement.
    always_comb begin
        // NOTE: every variable of this block is given its hold value first, so no path can infer a latch.
        act_d = act_q;
        for (int i = 0; i < N_BULLETS; i++) begin
            x_d[i]   = x_q[i];
            y_d[i]   = y_q[i];
            dir_d[i] = dir_q[i];

            if (ctl.fire && free_found && free_idx == IW'(i)) begin
                x_d[i]   = ctl.fire_x;
                y_d[i]   = ctl.fire_y;
                dir_d[i] = ctl.fire_dir;
                act_d[i] = 1'b1;
            end else if (ctl.kill && ctl.kill_idx == IW'(i) && act_q[i]) begin
                act_d[i] = 1'b0;
            end else if (frame_tick && act_q[i]) begin
                if (dir_q[i] == DIR_UP) begin
                    if ({1'b0, y_q[i]} < SPEED_EXT) act_d[i] = 1'b0;
                    else                            y_d[i]   = y_q[i] - SPEED_EXT[YW-1:0];
                end else begin
                    if ({1'b0, y_q[i]} + SPEED_EXT > Y_LIMIT) act_d[i] = 1'b0;
                    else                                      y_d[i]   = y_q[i] + SPEED_EXT[YW-1:0];
                end
            end
        end
    end

    // Rendering: offsets are plain unsigned differences, so a beam left of
    // or above the bullet wraps to a large value and falls outside the box.
    for (genvar g = 0; g < N_BULLETS; g++) begin : g_slot
        logic [XW-1:0] dx;
        logic [YW-1:0] dy;
        assign dx = pix_x - x_q[g];
        assign dy = pix_y - y_q[g];

        bullet_sprite_rom #(.XW(XW), .YW(YW)) u_rom (
            .en  (act_q[g]),
            .dy  (dy),
            .dx  (dx),
            .lit (lit[g])
        );
    end

    always_comb begin
        pix_on_d = |lit;
        pix_id_d = '0;
        for (int i = N_BULLETS - 1; i >= 0; i--) begin
            if (lit[i]) pix_id_d = IW'(i);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: slot storage is a few flops rather than a RAM, so it is reset with the mask and a reset leaves no stale position behind.
            for (int i = 0; i < N_BULLETS; i++) begin
                x_q[i]   <= '0;
                y_q[i]   <= '0;
                dir_q[i] <= DIR_UP;
            end
            act_q    <= '0;
            ack_q    <= 1'b0;
            drop_q   <= 1'b0;
            pix_on_q <= 1'b0;
            pix_id_q <= '0;
        end else begin
            // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
            for (int i = 0; i < N_BULLETS; i++) begin
                x_q[i]   <= x_d[i];
                y_q[i]   <= y_d[i];
                dir_q[i] <= dir_d[i];
            end
            act_q    <= act_d;
            ack_q    <= ctl.fire && free_found;
            drop_q   <= ctl.fire && !free_found;
            pix_on_q <= pix_on_d;
            pix_id_q <= pix_id_d;
        end
    end

    assign ctl.fire_ack  = ack_q;
    assign ctl.fire_drop = drop_q;
    assign pix_on        = pix_on_q;
    assign pix_id        = pix_id_q;
    assign active        = act_q;

endmodule

// File: tb/tb_bullet_pool.sv
// Self-checking bench for bullet_pool: directed scenarios followed by random
// traffic, every cycle compared against a behavioural model of the pool.
module tb_bullet_pool;
    import bullet_pkg::*;

    localparam int N     = 4;
    localparam int XW    = 10;
    localparam int YW    = 10;
    localparam int V_RES = 480;
    localparam int SPEED = 4;
    localparam int IW    = 2;

    logic          clk        = 1'b0;
    logic          rst_n      = 1'b0;
    logic          frame_tick = 1'b0;
    logic [XW-1:0] pix_x      = '0;
    logic [YW-1:0] pix_y      = '0;
    logic          pix_on;
    logic [IW-1:0] pix_id;
    logic [N-1:0]  active;

    bullet_pool_if #(.N_BULLETS(N), .XW(XW), .YW(YW)) ctl ();

    bullet_pool #(
        .N_BULLETS (N),
        .XW        (XW),
        .YW        (YW),
        .V_RES     (V_RES),
        .SPEED     (SPEED)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .frame_tick (frame_tick),
        .ctl        (ctl),
        .pix_x      (pix_x),
        .pix_y      (pix_y),
        .pix_on     (pix_on),
        .pix_id     (pix_id),
        .active     (active)
    );

    always #5 clk = ~clk;

    // Behavioural model: positions as plain integers.
    int m_x [N];
    int m_y [N];
    bit m_dn [N];
    bit m_act [N];
    bit m_ack, m_drop, m_on;
    int m_id;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Sprite shape: rows are centred runs of width 2,4,6,6,4,2.
    function automatic bit sprite_lit(input int dx, input int dy);
        int w;
        int d;
        if (dx < 0 || dx >= SPR || dy < 0 || dy >= SPR) return 1'b0;
        case (dy)
            0, 5:    w = 2;
            1, 4:    w = 4;
            default: w = 6;
        endcase
        d = 2 * dx - (SPR - 1);
        if (d < 0) d = -d;
        return d < w;
    endfunction

    function automatic logic [N-1:0] model_mask();
        logic [N-1:0] m;
        for (int i = 0; i < N; i++) m[i] = m_act[i];
        return m;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_x[i] = 0; m_y[i] = 0; m_dn[i] = 1'b0; m_act[i] = 1'b0;
        end
        m_ack = 1'b0; m_drop = 1'b0; m_on = 1'b0; m_id = 0;
    endtask

    // Apply one clock edge to the model using the inputs present before it.
    task automatic model_edge();
        int free;
        int id;
        bit on;
        free = -1; id = 0; on = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (m_act[i] && sprite_lit(int'(pix_x) - m_x[i], int'(pix_y) - m_y[i])) begin
                on = 1'b1; id = i;
            end
        end
        for (int i = N - 1; i >= 0; i--) if (!m_act[i]) free = i;
        m_on   = on;
        m_id   = id;
        m_ack  = ctl.fire && (free >= 0);
        m_drop = ctl.fire && (free < 0);
        for (int i = 0; i < N; i++) begin
            if (ctl.fire && i == free) begin
                m_x[i] = int'(ctl.fire_x); m_y[i] = int'(ctl.fire_y);
                m_dn[i] = (ctl.fire_dir == DIR_DN); m_act[i] = 1'b1;
            end else if (ctl.kill && int'(ctl.kill_idx) == i) begin
                m_act[i] = 1'b0;
            end else if (frame_tick && m_act[i]) begin
                if (m_dn[i]) begin
                    if (m_y[i] + SPEED > V_RES - SPR) m_act[i] = 1'b0;
                    else m_y[i] = m_y[i] + SPEED;
                end else begin
                    if (m_y[i] - SPEED < 0) m_act[i] = 1'b0;
                    else m_y[i] = m_y[i] - SPEED;
                end
            end
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".active"}, 32'(active), 32'(model_mask()));
        check({tag, ".ack"},    32'(ctl.fire_ack),  32'(m_ack));
        check({tag, ".drop"},   32'(ctl.fire_drop), 32'(m_drop));
        check({tag, ".pix_on"}, 32'(pix_on), 32'(m_on));
        check({tag, ".pix_id"}, 32'(pix_id), 32'(m_id));
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_all("step");
    endtask

    task automatic clear_inputs();
        ctl.fire = 1'b0; ctl.kill = 1'b0; frame_tick = 1'b0;
    endtask

    task automatic do_fire(input int x, input int y, input bit dn);
        ctl.fire = 1'b1; ctl.fire_x = XW'(x); ctl.fire_y = YW'(y);
        ctl.fire_dir = dn ? DIR_DN : DIR_UP;
        step();
        ctl.fire = 1'b0;
    endtask

    task automatic tick();
        frame_tick = 1'b1; step(); frame_tick = 1'b0; step();
    endtask

    task automatic set_pix(input int x, input int y);
        pix_x = XW'(x); pix_y = YW'(y); step();
    endtask

    task automatic kill_slot(input int idx);
        ctl.kill = 1'b1; ctl.kill_idx = IW'(idx); step(); ctl.kill = 1'b0;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        clear_inputs();
        model_reset();
        #1;
        check_all("reset");
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        ctl.fire = 1'b0; ctl.fire_x = '0; ctl.fire_y = '0; ctl.fire_dir = DIR_UP;
        ctl.kill = 1'b0; ctl.kill_idx = '0;

        // 1: single fire, three frames upward
        apply_reset();
        do_fire(100, 200, 1'b0);
        check("t1_ack", 32'(ctl.fire_ack), 32'd1);
        check("t1_active", 32'(active), 32'b0001);
        repeat (3) tick();
        set_pix(102, 188);
        check("t1_y188_on", 32'(pix_on), 32'd1);
        set_pix(102, 187);
        check("t1_above_off", 32'(pix_on), 32'd0);

        // 2: five back-to-back fires into four slots
        apply_reset();
        ctl.fire_x = XW'(10); ctl.fire_y = YW'(10); ctl.fire_dir = DIR_DN;
        ctl.fire = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            check("t2_ack",  32'(ctl.fire_ack),  32'(i < 4));
            check("t2_drop", 32'(ctl.fire_drop), 32'(i == 4));
        end
        ctl.fire = 1'b0;
        check("t2_active", 32'(active), 32'b1111);

        // 3: retire at both screen edges, and the last legal positions
        apply_reset();
        do_fire(50, 2, 1'b0);
        tick();
        check("t3_up_retire", 32'(active), 32'b0000);
        do_fire(50, 472, 1'b1);
        tick();
        check("t3_dn_retire", 32'(active), 32'b0000);
        do_fire(50, 470, 1'b1);
        tick();
        check("t3_dn_edge_keep", 32'(active), 32'b0001);
        kill_slot(0);
        do_fire(50, 4, 1'b0);
        tick();
        check("t3_up_edge_keep", 32'(active), 32'b0001);

        // 4: render inside, on a dark corner, and outside the box
        apply_reset();
        do_fire(100, 200, 1'b0);
        set_pix(102, 200);
        check("t4_lit", 32'(pix_on), 32'd1);
        set_pix(100, 200);
        check("t4_corner", 32'(pix_on), 32'd0);
        set_pix(106, 203);
        check("t4_outside", 32'(pix_on), 32'd0);

        // 5: tick + kill + fire in one cycle
        apply_reset();
        do_fire(10, 10, 1'b0);
        do_fire(20, 20, 1'b0);
        kill_slot(0);
        frame_tick = 1'b1; ctl.kill = 1'b1; ctl.kill_idx = IW'(1);
        do_fire(30, 40, 1'b1);
        clear_inputs();
        check("t5_active", 32'(active), 32'b0001);
        set_pix(32, 40);
        check("t5_unmoved_on", 32'(pix_on), 32'd1);
        check("t5_unmoved_id", 32'(pix_id), 32'd0);

        // 6: overlap priority, then asynchronous reset mid-frame
        apply_reset();
        do_fire(100, 200, 1'b0);
        do_fire(300, 300, 1'b1);
        do_fire(100, 200, 1'b1);
        set_pix(102, 201);
        check("t6_overlap_on", 32'(pix_on), 32'd1);
        check("t6_overlap_id", 32'(pix_id), 32'd0);
        kill_slot(0);
        step();
        check("t6_after_kill_id", 32'(pix_id), 32'd2);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check("t6_rst_active", 32'(active), 32'd0);
        check("t6_rst_pix_on", 32'(pix_on), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Random traffic against the model
        for (int c = 0; c < 3000; c++) begin
            int s;
            ctl.fire     = ($urandom_range(0, 99) < 30);
            ctl.fire_x   = XW'($urandom_range(0, 633));
            ctl.fire_y   = YW'($urandom_range(0, V_RES - SPR - 1));
            ctl.fire_dir = ($urandom_range(0, 1) == 1) ? DIR_DN : DIR_UP;
            ctl.kill     = ($urandom_range(0, 99) < 10);
            ctl.kill_idx = IW'($urandom_range(0, N - 1));
            frame_tick   = ($urandom_range(0, 99) < 30);
            if ($urandom_range(0, 3) != 0) begin
                s = $urandom_range(0, N - 1);
                pix_x = XW'(m_x[s] + $urandom_range(0, 7) - 1);
                pix_y = YW'(m_y[s] + $urandom_range(0, 7) - 1);
            end else begin
                pix_x = XW'($urandom_range(0, 639));
                pix_y = YW'($urandom_range(0, 479));
            end
            step();
        end

        clear_inputs();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
